// File: rtl/dcache_pkg.sv
// dcache_pkg: shared state type, array geometry and address-field helpers
// for the data cache request controller.
package dcache_pkg;

    localparam int TAG_W      = 18;
    localparam int IDX_W      = 8;
    localparam int LINE_BEATS = 4;
    localparam int BEAT_W     = 2;
    localparam int WORD_W     = 32;
    localparam int BEAT_BITS  = 128;

    typedef enum logic [3:0] {
        IDLE,
        TAGCHK,
        STORE,
        WB_RD,
        WB_SEND,
        WB_REQ,
        RF_REQ,
        RF_WAIT,
        REPLAY
    } state_t;

    // Byte address layout: [31:14] tag, [13:6] index, [5:4] beat, [3:2] word.
    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31:14];
    endfunction

    function automatic logic [IDX_W-1:0] addr_index(input logic [31:0] addr);
        return addr[13:6];
    endfunction

    function automatic logic [BEAT_W-1:0] addr_beat(input logic [31:0] addr);
        return addr[5:4];
    endfunction

    function automatic logic [1:0] addr_word(input logic [31:0] addr);
        return addr[3:2];
    endfunction

    // Line-aligned byte address of a tag/index pair.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [IDX_W-1:0] index);
        return {tag, index, 6'b0};
    endfunction

    // One 32-bit word out of a 128-bit beat.
    function automatic logic [WORD_W-1:0] beat_word(input logic [BEAT_BITS-1:0] beat,
                                                    input logic [1:0]           word);
        return beat[{word, 5'b0} +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_store_merge.sv
// dcache_store_merge: replaces one 32-bit word of a 128-bit beat with store data.
module dcache_store_merge
    import dcache_pkg::*;
(
    input  logic [BEAT_BITS-1:0] line,
    input  logic [1:0]           word,
    input  logic [WORD_W-1:0]    wdata,
    output logic [BEAT_BITS-1:0] merged
);

    // Keep the other three words, overwrite the selected one.
    always_comb begin
        merged                          = line;
        merged[{word, 5'b0} +: WORD_W] = wdata;
    end

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: request-side controller for the 4-way, 256-set data cache array.
// One CPU access at a time: tag check, then on a miss an optional dirty-victim
// write-back and a line refill, followed by a replayed tag check that lets the
// array update its own PLRU/valid/dirty metadata.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int BEATS  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_W-1:0]    cpu_addr,
    input  logic [WORD_W-1:0]    cpu_wdata,
    output logic                 cpu_ready,
    output logic                 cpu_done,
    output logic [WORD_W-1:0]    cpu_rdata,

    output logic                 dc_r,
    output logic                 dc_w,
    output logic                 dc_w_tagcheck,
    output logic                 dc_no_tagcheck_read,
    output logic [IDX_W-1:0]     dc_r_index,
    output logic [IDX_W-1:0]     dc_w_index,
    output logic [TAG_W-1:0]     dc_r_tag,
    output logic [TAG_W-1:0]     dc_w_tag,
    output logic [5:0]           dc_r_line,
    output logic [5:0]           dc_w_line,
    output logic [1:0]           dc_w_way,
    output logic [1:0]           dc_no_tagcheck_way,
    output logic [1:0]           dc_flushtype,
    output logic [BEAT_BITS-1:0] dc_w_data,
    input  logic                 dc_hit,
    input  logic                 dc_dirty,
    input  logic [1:0]           dc_way,
    input  logic [TAG_W-1:0]     dc_tag_out,
    input  logic [BEAT_BITS-1:0] dc_data_out,

    output logic                 mem_req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ack,
    output logic [BEAT_BITS-1:0] mem_wdata,
    output logic                 mem_wvalid,
    input  logic                 mem_wready,
    input  logic [BEAT_BITS-1:0] mem_rdata,
    input  logic                 mem_rvalid
);

    state_t                state, state_nx;
    logic [ADDR_W-1:0]     req_addr;
    logic                  req_we;
    logic [WORD_W-1:0]     req_wdata;
    logic [1:0]            hit_way;
    logic [1:0]            victim_way;
    logic [TAG_W-1:0]      victim_tag;
    logic [BEAT_W-1:0]     beat;
    logic [BEAT_BITS-1:0]  line_buf;
    logic                  wb_fresh;
    logic [BEAT_BITS-1:0]  store_line;
    logic                  last_beat;
    logic                  unused_bits;

    assign last_beat    = (beat == BEAT_W'(BEATS - 1));
    assign dc_flushtype = 2'b00;
    // Byte-within-word bits never reach the array or memory.
    assign unused_bits  = ^{req_addr[1:0]};

    dcache_store_merge u_store_merge (
        .line   (line_buf),
        .word   (addr_word(req_addr)),
        .wdata  (req_wdata),
        .merged (store_line)
    );

    // State register plus request, victim and beat bookkeeping.
    // NOTE: reset is synchronous and active-high, so it is tested inside the clocked
    // branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_addr   <= '0;
            req_we     <= 1'b0;
            req_wdata  <= '0;
            hit_way    <= '0;
            victim_way <= '0;
            victim_tag <= '0;
            beat       <= '0;
            line_buf   <= '0;
            wb_fresh   <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all of them see the same
            // pre-edge values regardless of statement order.
            state    <= state_nx;
            wb_fresh <= (state == WB_RD);
            unique case (state)
                IDLE: begin
                    if (cpu_req) begin
                        req_addr  <= cpu_addr;
                        req_we    <= cpu_we;
                        req_wdata <= cpu_wdata;
                    end
                end
                TAGCHK: begin
                    // The array only presents its response for one cycle.
                    line_buf <= dc_data_out;
                    hit_way  <= dc_way;
                    if (!dc_hit) begin
                        victim_way <= dc_way;
                        victim_tag <= dc_tag_out;
                    end
                end
                WB_REQ, RF_REQ: begin
                    if (mem_ack) beat <= '0;
                end
                WB_SEND: begin
                    // Hold the victim beat locally while memory stalls.
                    if (wb_fresh) line_buf <= dc_data_out;
                    if (mem_wready) beat <= beat + 1'b1;
                end
                RF_WAIT: begin
                    if (mem_rvalid) beat <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and all array/memory/CPU strobes.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_nx            = state;
        cpu_ready           = 1'b0;
        cpu_done            = 1'b0;
        cpu_rdata           = '0;
        dc_r                = 1'b0;
        dc_w                = 1'b0;
        dc_w_tagcheck       = 1'b0;
        dc_no_tagcheck_read = 1'b0;
        dc_r_index          = '0;
        dc_r_tag            = '0;
        dc_r_line           = '0;
        dc_w_index          = '0;
        dc_w_tag            = '0;
        dc_w_line           = '0;
        dc_w_way            = '0;
        dc_no_tagcheck_way  = '0;
        dc_w_data           = '0;
        mem_req             = 1'b0;
        mem_we              = 1'b0;
        mem_addr            = '0;
        mem_wdata           = '0;
        mem_wvalid          = 1'b0;

        unique case (state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    dc_r          = 1'b1;
                    dc_r_index    = addr_index(cpu_addr);
                    dc_r_tag      = addr_tag(cpu_addr);
                    dc_r_line     = {addr_beat(cpu_addr), 4'b0};
                    dc_w_tagcheck = cpu_we;
                    state_nx      = TAGCHK;
                end
            end
            TAGCHK: begin
                if (dc_hit) begin
                    if (req_we) begin
                        state_nx = STORE;
                    end else begin
                        cpu_done  = 1'b1;
                        cpu_rdata = beat_word(dc_data_out, addr_word(req_addr));
                        state_nx  = IDLE;
                    end
                end else begin
                    state_nx = dc_dirty ? WB_REQ : RF_REQ;
                end
            end
            STORE: begin
                dc_w       = 1'b1;
                dc_w_way   = hit_way;
                dc_w_index = addr_index(req_addr);
                dc_w_tag   = addr_tag(req_addr);
                dc_w_line  = {addr_beat(req_addr), 4'b0};
                dc_w_data  = store_line;
                cpu_done   = 1'b1;
                state_nx   = IDLE;
            end
            WB_REQ: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                mem_addr = line_addr(victim_tag, addr_index(req_addr));
                if (mem_ack) state_nx = WB_RD;
            end
            WB_RD: begin
                dc_r                = 1'b1;
                dc_no_tagcheck_read = 1'b1;
                dc_no_tagcheck_way  = victim_way;
                dc_r_index          = addr_index(req_addr);
                dc_r_tag            = victim_tag;
                dc_r_line           = {beat, 4'b0};
                state_nx            = WB_SEND;
            end
            WB_SEND: begin
                mem_wvalid = 1'b1;
                mem_wdata  = wb_fresh ? dc_data_out : line_buf;
                if (mem_wready) state_nx = last_beat ? RF_REQ : WB_RD;
            end
            RF_REQ: begin
                mem_req  = 1'b1;
                mem_addr = line_addr(addr_tag(req_addr), addr_index(req_addr));
                if (mem_ack) state_nx = RF_WAIT;
            end
            RF_WAIT: begin
                if (mem_rvalid) begin
                    dc_w       = 1'b1;
                    dc_w_way   = victim_way;
                    dc_w_index = addr_index(req_addr);
                    dc_w_tag   = addr_tag(req_addr);
                    dc_w_line  = {beat, 4'b0};
                    dc_w_data  = mem_rdata;
                    if (last_beat) state_nx = REPLAY;
                end
            end
            REPLAY: begin
                dc_r          = 1'b1;
                dc_r_index    = addr_index(req_addr);
                dc_r_tag      = addr_tag(req_addr);
                dc_r_line     = {addr_beat(req_addr), 4'b0};
                dc_w_tagcheck = req_we;
                state_nx      = TAGCHK;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed bench with a behavioural 4-way array, a memory
// responder and a scoreboard of expected CPU completions and memory transactions.
module tb_dcache_ctrl;

    typedef struct {
        logic        we;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
    } mem_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req, cpu_we, cpu_ready, cpu_done;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         dc_r, dc_w, dc_w_tagcheck, dc_no_tagcheck_read;
    logic [7:0]   dc_r_index, dc_w_index;
    logic [17:0]  dc_r_tag, dc_w_tag;
    logic [5:0]   dc_r_line, dc_w_line;
    logic [1:0]   dc_w_way, dc_no_tagcheck_way, dc_flushtype;
    logic [127:0] dc_w_data;
    logic         dc_hit, dc_dirty;
    logic [1:0]   dc_way;
    logic [17:0]  dc_tag_out;
    logic [127:0] dc_data_out;
    logic         mem_req, mem_we, mem_ack, mem_wvalid, mem_wready, mem_rvalid;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    sb_t  sb[$];
    mem_t mem_exp[$];
    logic [31:0] ref_word  [logic [31:0]];
    logic [31:0] mem_store [logic [31:0]];

    int          done_cnt = 0;
    int          done_cyc = 0;
    int          done_gap = 0;
    int          stall_beat;
    int          abort_beats;
    bit          rf_aborted = 1'b0;
    logic [1:0]  st_word;
    logic [31:0] st_data;

    // Array model state.
    logic [17:0]  a_tag    [256][4];
    logic         a_val    [256][4];
    logic         a_dirty  [256][4];
    logic [127:0] a_data   [256][4][4];
    int           a_cnt    [256][4];
    longint       a_use    [256][4];
    logic [1:0]   a_victim [256];
    int           a_rfbeat [256];
    longint       use_clk = 0;
    bit           m_init  = 1'b0;
    int           m_wi, m_wb, m_ww, m_ri, m_rb, m_hw, m_v;

    dcache_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .cpu_req             (cpu_req),
        .cpu_we              (cpu_we),
        .cpu_addr            (cpu_addr),
        .cpu_wdata           (cpu_wdata),
        .cpu_ready           (cpu_ready),
        .cpu_done            (cpu_done),
        .cpu_rdata           (cpu_rdata),
        .dc_r                (dc_r),
        .dc_w                (dc_w),
        .dc_w_tagcheck       (dc_w_tagcheck),
        .dc_no_tagcheck_read (dc_no_tagcheck_read),
        .dc_r_index          (dc_r_index),
        .dc_w_index          (dc_w_index),
        .dc_r_tag            (dc_r_tag),
        .dc_w_tag            (dc_w_tag),
        .dc_r_line           (dc_r_line),
        .dc_w_line           (dc_w_line),
        .dc_w_way            (dc_w_way),
        .dc_no_tagcheck_way  (dc_no_tagcheck_way),
        .dc_flushtype        (dc_flushtype),
        .dc_w_data           (dc_w_data),
        .dc_hit              (dc_hit),
        .dc_dirty            (dc_dirty),
        .dc_way              (dc_way),
        .dc_tag_out          (dc_tag_out),
        .dc_data_out         (dc_data_out),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_ack             (mem_ack),
        .mem_wdata           (mem_wdata),
        .mem_wvalid          (mem_wvalid),
        .mem_wready          (mem_wready),
        .mem_rdata           (mem_rdata),
        .mem_rvalid          (mem_rvalid)
    );

    always #5 clk = ~clk;

    // Posedge cycle counter, read on negedges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Value the CPU should see at a word address (stores applied at issue time).
    function automatic logic [31:0] exp_word(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        return ref_word.exists(wa) ? ref_word[wa] : (wa ^ 32'h5A5A_0000);
    endfunction

    // Contents of backing memory at a word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return mem_store.exists(a) ? mem_store[a] : (a ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [127:0] ref_beat(input logic [31:0] a);
        return {exp_word(a + 12), exp_word(a + 8), exp_word(a + 4), exp_word(a)};
    endfunction

    function automatic logic [127:0] mem_beat(input logic [31:0] a);
        return {mem_word(a + 12), mem_word(a + 8), mem_word(a + 4), mem_word(a)};
    endfunction

    function automatic logic [127:0] put_word(input logic [127:0] l, input logic [1:0] w,
                                              input logic [31:0] d);
        logic [127:0] r;
        r = l;
        r[w*32 +: 32] = d;
        return r;
    endfunction

    // Behavioural array: synchronous read, LRU victim choice, owns all metadata.
    always @(posedge clk) begin
        if (!m_init) begin
            for (int s = 0; s < 256; s++) begin
                for (int w = 0; w < 4; w++) begin
                    a_val[s][w]   = 1'b0;
                    a_dirty[s][w] = 1'b0;
                    a_cnt[s][w]   = 0;
                    a_use[s][w]   = 0;
                    a_tag[s][w]   = '0;
                end
                a_victim[s] = '0;
                a_rfbeat[s] = 0;
            end
            m_init = 1'b1;
        end
        if (dc_w) begin
            m_wi = int'(dc_w_index);
            m_wb = int'(dc_w_line[5:4]);
            m_ww = int'(dc_w_way);
            if (a_val[m_wi][m_ww] && a_tag[m_wi][m_ww] == dc_w_tag) begin
                check("store_wdata", dc_w_data, put_word(a_data[m_wi][m_ww][m_wb], st_word, st_data));
            end else begin
                check("refill_way", dc_w_way, a_victim[m_wi]);
                check("refill_beat", m_wb, a_rfbeat[m_wi]);
                check("refill_data", dc_w_data, mem_beat({dc_w_tag, dc_w_index, dc_w_line[5:4], 4'b0}));
                if (m_wb == 0) begin
                    a_tag[m_wi][m_ww]   = dc_w_tag;
                    a_val[m_wi][m_ww]   = 1'b0;
                    a_dirty[m_wi][m_ww] = 1'b0;
                    a_cnt[m_wi][m_ww]   = 0;
                end
                a_cnt[m_wi][m_ww]++;
                a_rfbeat[m_wi]++;
                if (a_cnt[m_wi][m_ww] == 4) a_val[m_wi][m_ww] = 1'b1;
            end
            a_data[m_wi][m_ww][m_wb] = dc_w_data;
        end
        if (dc_r) begin
            m_ri = int'(dc_r_index);
            m_rb = int'(dc_r_line[5:4]);
            if (dc_no_tagcheck_read) begin
                m_v = int'(dc_no_tagcheck_way);
                dc_hit      <= 1'b0;
                dc_way      <= dc_no_tagcheck_way;
                dc_tag_out  <= a_tag[m_ri][m_v];
                dc_dirty    <= a_dirty[m_ri][m_v];
                dc_data_out <= a_data[m_ri][m_v][m_rb];
            end else begin
                m_hw = -1;
                for (int w = 0; w < 4; w++)
                    if (a_val[m_ri][w] && a_tag[m_ri][w] == dc_r_tag) m_hw = w;
                if (m_hw >= 0) begin
                    use_clk++;
                    a_use[m_ri][m_hw] = use_clk;
                    if (dc_w_tagcheck) a_dirty[m_ri][m_hw] = 1'b1;
                    dc_hit      <= 1'b1;
                    dc_way      <= 2'(m_hw);
                    dc_tag_out  <= a_tag[m_ri][m_hw];
                    dc_dirty    <= a_dirty[m_ri][m_hw];
                    dc_data_out <= a_data[m_ri][m_hw][m_rb];
                end else begin
                    m_v = -1;
                    for (int w = 3; w >= 0; w--) if (!a_val[m_ri][w]) m_v = w;
                    if (m_v < 0) begin
                        m_v = 0;
                        for (int w = 1; w < 4; w++)
                            if (a_use[m_ri][w] < a_use[m_ri][m_v]) m_v = w;
                    end
                    a_victim[m_ri] = 2'(m_v);
                    a_rfbeat[m_ri] = 0;
                    dc_hit      <= 1'b0;
                    dc_way      <= 2'(m_v);
                    dc_tag_out  <= a_tag[m_ri][m_v];
                    dc_dirty    <= a_val[m_ri][m_v] && a_dirty[m_ri][m_v];
                    dc_data_out <= a_data[m_ri][m_v][m_rb];
                end
            end
        end
    end

    // Memory responder: checks each transaction against the expected queue.
    initial begin
        logic        t_we;
        logic [31:0] t_addr;
        mem_t        e;
        int          n;
        mem_ack    = 1'b0;
        mem_wready = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !rst) begin
                t_we   = mem_we;
                t_addr = mem_addr;
                if (mem_exp.size() == 0) begin
                    check("mem_unexpected_req", {t_we, t_addr}, '0);
                end else begin
                    e = mem_exp.pop_front();
                    check("mem_we", t_we, e.we);
                    check("mem_addr", t_addr, e.addr);
                end
                mem_ack = 1'b1;
                @(negedge clk);
                mem_ack = 1'b0;
                if (t_we) begin
                    for (int b = 0; b < 4; b++) begin
                        n = 0;
                        while (!mem_wvalid && n < 50) begin
                            @(negedge clk);
                            n++;
                        end
                        check("wb_wvalid", mem_wvalid, 1'b1);
                        if (b == stall_beat) begin
                            for (int s = 0; s < 5; s++) begin
                                check("wb_hold_valid", mem_wvalid, 1'b1);
                                check("wb_hold_data", mem_wdata, ref_beat(t_addr + 32'(b * 16)));
                                @(negedge clk);
                            end
                        end
                        check("wb_beat", mem_wdata, ref_beat(t_addr + 32'(b * 16)));
                        for (int w = 0; w < 4; w++)
                            mem_store[t_addr + 32'(b * 16 + w * 4)] = mem_wdata[w*32 +: 32];
                        mem_wready = 1'b1;
                        @(negedge clk);
                        mem_wready = 1'b0;
                    end
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (b == abort_beats) begin
                            rf_aborted = 1'b1;
                            break;
                        end
                        mem_rdata  = mem_beat(t_addr + 32'(b * 16));
                        mem_rvalid = 1'b1;
                        @(negedge clk);
                        mem_rvalid = 1'b0;
                        @(negedge clk);
                    end
                end
            end
        end
    end

    // Completion monitor: pops the scoreboard on every cpu_done pulse.
    initial begin
        sb_t s;
        forever begin
            @(negedge clk);
            if (cpu_done) begin
                done_gap = cyc - done_cyc;
                done_cyc = cyc;
                done_cnt++;
                if (sb.size() == 0) begin
                    check("done_unexpected", {cpu_done, cpu_rdata}, '0);
                end else begin
                    s = sb.pop_front();
                    if (!s.we) begin
                        check("load_rdata", cpu_rdata, s.data);
                        check("ready_low_in_tagchk", cpu_ready, 1'b0);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (!cpu_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("ready_timeout", cpu_ready, 1'b1);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        @(negedge clk);
        #1;
        cpu_req   = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int exp_lat);
        sb_t s;
        int  n, start, target;
        wait_ready();
        s.we   = we;
        s.data = we ? 32'h0 : exp_word(addr);
        if (we) begin
            ref_word[{addr[31:2], 2'b00}] = wdata;
            st_word = addr[3:2];
            st_data = wdata;
        end
        sb.push_back(s);
        target = done_cnt + 1;
        start  = cyc;
        issue(we, addr, wdata);
        n = 0;
        while (done_cnt < target && n < 400) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_timeout", done_cnt, target);
        if (exp_lat != 0) check("latency", done_cyc - start + 1, exp_lat);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        cpu_req     = 1'b0;
        cpu_we      = 1'b0;
        cpu_addr    = '0;
        cpu_wdata   = '0;
        st_word     = '0;
        st_data     = '0;
        stall_beat  = -1;
        abort_beats = -1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", cpu_ready, 1'b1);
        check("rst_done", cpu_done, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_dc_r", dc_r, 1'b0);
        check("rst_dc_w", dc_w, 1'b0);
        check("rst_wvalid", mem_wvalid, 1'b0);
        check("rst_flushtype", dc_flushtype, 2'b00);
        rst = 1'b0;

        // Cold miss, clean victim, refill then replayed hit.
        mem_exp.push_back('{we: 1'b0, addr: 32'h0000_1040});
        do_req(1'b0, 32'h0000_1040, 32'h0, 0);
        mem_exp.push_back('{we: 1'b0, addr: 32'h0000_5040});
        do_req(1'b0, 32'h0000_5040, 32'h0, 0);

        // Store hit on word 2, then read it back.
        do_req(1'b1, 32'h0000_5048, 32'hDEAD_BEEF, 3);
        do_req(1'b0, 32'h0000_5048, 32'h0, 2);

        // Fill the remaining ways of set 0x41.
        mem_exp.push_back('{we: 1'b0, addr: 32'h0000_9040});
        do_req(1'b0, 32'h0000_9044, 32'h0, 0);
        mem_exp.push_back('{we: 1'b0, addr: 32'h0000_D040});
        do_req(1'b0, 32'h0000_D07C, 32'h0, 0);

        // Back-to-back hits.
        do_req(1'b0, 32'h0000_1044, 32'h0, 2);
        do_req(1'b0, 32'h0000_104C, 32'h0, 2);
        check("b2b_gap", done_gap, 2);

        // Miss evicting the dirty tag-1 line, with memory stalling beat 1.
        stall_beat = 1;
        mem_exp.push_back('{we: 1'b1, addr: 32'h0000_5040});
        mem_exp.push_back('{we: 1'b0, addr: 32'h0001_1040});
        do_req(1'b0, 32'h0001_1058, 32'h0, 0);
        stall_beat = -1;

        // Reset in the middle of a refill, after beat 2 has been written.
        abort_beats = 3;
        mem_exp.push_back('{we: 1'b0, addr: 32'h0001_5040});
        wait_ready();
        issue(1'b0, 32'h0001_5040, 32'h0);
        n = 0;
        while (!rf_aborted && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("abort_reached", rf_aborted, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_ready", cpu_ready, 1'b1);
        check("midrst_mem_req", mem_req, 1'b0);
        check("midrst_dc_w", dc_w, 1'b0);
        check("midrst_done", cpu_done, 1'b0);
        rst = 1'b0;
        abort_beats = -1;

        // The partial line was never validated, so this misses again.
        mem_exp.push_back('{we: 1'b0, addr: 32'h0001_5040});
        do_req(1'b0, 32'h0001_5040, 32'h0, 0);

        repeat (4) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("mem_exp_drained", mem_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
